// File: rtl/counter_enable_gen.sv
// Programmable prescaler that paces a downstream counter with single-cycle
// enable pulses, either free-running (RUN) or for a fixed count (BURST).
module counter_enable_gen #(
  parameter int DIV_WIDTH   = 8,
  parameter int BURST_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DIV_WIDTH-1:0]   div_value,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   burst_mode,
  input  logic                   start,
  input  logic                   stop,
  output logic                   enable,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] pulses_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BURST = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0]   DIV_ONE   = 1;
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = 1;

  state_t                 state, state_next;
  logic [DIV_WIDTH-1:0]   div_q, div_q_next;
  logic [DIV_WIDTH-1:0]   div_cnt, div_cnt_next;
  logic [BURST_WIDTH-1:0] pulses_next;
  logic                   enable_next;
  logic                   done_next;
  logic                   start_ok;
  logic                   tick;

  assign start_ok = start && !stop;
  assign tick     = (div_cnt == div_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      enable      <= 1'b0;
      done        <= 1'b0;
      pulses_left <= '0;
      div_q       <= '0;
      div_cnt     <= '0;
    end else begin
      state       <= state_next;
      busy        <= (state_next != IDLE);
      enable      <= enable_next;
      done        <= done_next;
      pulses_left <= pulses_next;
      div_q       <= div_q_next;
      div_cnt     <= div_cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          if (!burst_mode)
            state_next = RUN;
          else if (burst_len != '0)
            state_next = BURST;
        end
      end
      RUN: begin
        if (stop)
          state_next = IDLE;
      end
      BURST: begin
        if (stop || (pulses_left == '0))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A burst ends one edge after its last pulse, which is when done fires.
  always_comb begin
    div_q_next   = div_q;
    div_cnt_next = div_cnt;
    pulses_next  = pulses_left;
    enable_next  = 1'b0;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          div_q_next   = div_value;
          div_cnt_next = '0;
          if (burst_mode) begin
            if (burst_len != '0)
              pulses_next = burst_len;
            else
              done_next = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          div_cnt_next = '0;
        end else if (tick) begin
          div_cnt_next = '0;
          enable_next  = 1'b1;
        end else begin
          div_cnt_next = div_cnt + DIV_ONE;
        end
      end
      BURST: begin
        if (stop) begin
          div_cnt_next = '0;
          pulses_next  = '0;
        end else if (pulses_left == '0) begin
          div_cnt_next = '0;
          done_next    = 1'b1;
        end else if (tick) begin
          div_cnt_next = '0;
          enable_next  = 1'b1;
          pulses_next  = pulses_left - BURST_ONE;
        end else begin
          div_cnt_next = div_cnt + DIV_ONE;
        end
      end
      default: begin
        div_cnt_next = '0;
        pulses_next  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_enable_gen.sv
// Scoreboard bench for counter_enable_gen: directed scenarios queue expected
// enable/done events by cycle and a negedge monitor matches them.
module tb_counter_enable_gen;

  localparam int DW = 8;
  localparam int BW = 5;
  localparam bit EV_EN   = 1'b0;
  localparam bit EV_DONE = 1'b1;

  typedef struct {
    bit kind;
    int cyc;
  } ev_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] div_value;
  logic [BW-1:0] burst_len;
  logic          burst_mode;
  logic          start;
  logic          stop;
  logic          enable;
  logic          busy;
  logic          done;
  logic [BW-1:0] pulses_left;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   enable_total = 0;
  logic [3:0] count4;
  ev_t  sb[$];

  counter_enable_gen #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clock(clock),
    .reset(reset),
    .div_value(div_value),
    .burst_len(burst_len),
    .burst_mode(burst_mode),
    .start(start),
    .stop(stop),
    .enable(enable),
    .busy(busy),
    .done(done),
    .pulses_left(pulses_left)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Stand-in for the downstream 4-bit counter this block paces.
  always @(posedge clock or negedge reset) begin
    if (!reset)
      count4 <= 4'd0;
    else if (enable)
      count4 <= count4 + 4'd1;
  end

  always @(posedge clock) begin
    if (reset && enable)
      enable_total <= enable_total + 1;
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected)
      n_pass++;
    else
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
  endtask

  task automatic matchEvent(input bit kind);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("[TB] FAIL unexpected_%s: seen at cycle %0d, expected none", kind ? "done" : "enable", cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind == kind && e.cyc == cyc)
        n_pass++;
      else
        $display("[TB] FAIL event_order: got %s at cycle %0d, expected %s at cycle %0d",
                 kind ? "done" : "enable", cyc, e.kind ? "done" : "enable", e.cyc);
    end
  endtask

  // Monitor: overdue entries are misses, every enable/done must match the head.
  always @(negedge clock) begin
    if (reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_checks++;
        $display("[TB] FAIL missing_%s: got nothing at cycle %0d, expected event",
                 sb[0].kind ? "done" : "enable", sb[0].cyc);
        void'(sb.pop_front());
      end
      if (enable) matchEvent(EV_EN);
      if (done)   matchEvent(EV_DONE);
    end
  end

  task automatic pushEv(input bit kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic pushEnables(input int first, input int period, input int n);
    for (int i = 0; i < n; i++)
      pushEv(EV_EN, first + i * period);
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic mode,
                               input logic [DW-1:0] dv, input logic [BW-1:0] bl);
    start      = st;
    stop       = sp;
    burst_mode = mode;
    div_value  = dv;
    burst_len  = bl;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  // Drives start for one edge; returns the index of that edge (E0).
  task automatic startOp(input logic mode, input logic [DW-1:0] dv, input logic [BW-1:0] bl,
                         output int e0);
    e0 = cyc + 1;
    applyStimulus(1'b1, 1'b0, mode, dv, bl);
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int e0;
    logic [3:0] c0;
    int t0;

    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clock);
    checkOutput("rst_enable", enable, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pulses_left", pulses_left, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Reset in the middle of a RUN (div=2), while enable is high.
    e0 = cyc + 1;
    pushEv(EV_EN, e0 + 3);
    startOp(1'b0, 8'd2, 5'd0, e0);
    waitUntil(e0 + 3);
    #1 reset = 1'b0;
    #1;
    checkOutput("t1_async_enable", enable, 0);
    checkOutput("t1_async_busy", busy, 0);
    checkOutput("t1_async_done", done, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    t0 = cyc;
    waitUntil(t0 + 10);
    checkOutput("t1_idle_busy", busy, 0);
    checkOutput("t1_no_pulses", count4, 0);
    checkOutput("t1_sb_empty", sb.size(), 0);

    // RUN div=3, stop sampled at E10 suppresses the E12 pulse.
    e0 = cyc + 1;
    pushEnables(e0 + 4, 4, 2);
    startOp(1'b0, 8'd3, 5'd0, e0);
    waitUntil(e0 + 5);
    checkOutput("t2_busy_run", busy, 1);
    waitUntil(e0 + 9);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    checkOutput("t2_stop_busy", busy, 0);
    checkOutput("t2_stop_enable", enable, 0);
    waitUntil(e0 + 16);
    checkOutput("t2_sb_empty", sb.size(), 0);

    // RUN div=0 is continuous; changing div_value mid-run has no effect.
    e0 = cyc + 1;
    pushEnables(e0 + 1, 1, 7);
    startOp(1'b0, 8'd0, 5'd0, e0);
    waitUntil(e0 + 3);
    div_value = 8'd5;
    waitUntil(e0 + 7);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    checkOutput("t3_stop_enable", enable, 0);
    waitUntil(e0 + 14);
    checkOutput("t3_sb_empty", sb.size(), 0);

    // BURST div=1 len=5: pulses at E2..E10, done at E11.
    c0 = count4;
    e0 = cyc + 1;
    pushEnables(e0 + 2, 2, 5);
    pushEv(EV_DONE, e0 + 11);
    startOp(1'b1, 8'd1, 5'd5, e0);
    checkOutput("t4_pulses_left_load", pulses_left, 5);
    waitUntil(e0 + 2);
    checkOutput("t4_pulses_left_dec", pulses_left, 4);
    waitUntil(e0 + 10);
    checkOutput("t4_busy_last", busy, 1);
    checkOutput("t4_pulses_left_zero", pulses_left, 0);
    waitUntil(e0 + 11);
    checkOutput("t4_busy_end", busy, 0);
    waitUntil(e0 + 15);
    checkOutput("t4_counter_adv", count4, c0 + 4'd5);
    checkOutput("t4_sb_empty", sb.size(), 0);

    // BURST len=0: immediate done, never busy.
    e0 = cyc + 1;
    pushEv(EV_DONE, e0);
    startOp(1'b1, 8'd7, 5'd0, e0);
    checkOutput("t5a_busy", busy, 0);
    waitUntil(e0 + 4);
    checkOutput("t5a_busy_after", busy, 0);
    checkOutput("t5a_sb_empty", sb.size(), 0);

    // BURST div=0 len=16: 16 back-to-back pulses wrap the 4-bit counter.
    c0 = count4;
    t0 = enable_total;
    e0 = cyc + 1;
    pushEnables(e0 + 1, 1, 16);
    pushEv(EV_DONE, e0 + 17);
    startOp(1'b1, 8'd0, 5'd16, e0);
    waitUntil(e0 + 16);
    checkOutput("t5b_busy_last", busy, 1);
    waitUntil(e0 + 17);
    checkOutput("t5b_busy_end", busy, 0);
    waitUntil(e0 + 20);
    checkOutput("t5b_counter_wrap", count4, c0);
    checkOutput("t5b_enable_total", enable_total - t0, 16);
    checkOutput("t5b_sb_empty", sb.size(), 0);

    // start and stop together in IDLE: nothing happens.
    e0 = cyc + 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd3, 5'd4);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 5'd0);
    checkOutput("t6a_busy", busy, 0);
    checkOutput("t6a_pulses_left", pulses_left, 0);
    waitUntil(e0 + 5);
    checkOutput("t6a_busy_after", busy, 0);
    checkOutput("t6a_sb_empty", sb.size(), 0);

    // stop in BURST with three pulses remaining: abort, no done.
    e0 = cyc + 1;
    pushEnables(e0 + 2, 2, 2);
    startOp(1'b1, 8'd1, 5'd5, e0);
    waitUntil(e0 + 4);
    checkOutput("t6b_pulses_left", pulses_left, 3);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    checkOutput("t6b_busy", busy, 0);
    checkOutput("t6b_pulses_cleared", pulses_left, 0);
    checkOutput("t6b_enable", enable, 0);
    waitUntil(e0 + 12);
    checkOutput("t6b_sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
